// File: rtl/hbm_rd_responder_single_if.sv
// Edge-fetch request/response stream plus the single-beat AXI4 read channel of one HBM
// pseudo channel. "master" is the responder's view, "slave" the environment's.
interface hbm_rd_responder_single_if #(
  parameter int unsigned HBM_AWIDTH = 32,
  parameter int unsigned HBM_DWIDTH = 256,
  parameter int unsigned AXI_AWIDTH = 33
);
  logic [HBM_AWIDTH-1:0] rd_hbm_edge_addr;
  logic                  rd_hbm_edge_valid;
  logic                  hbm_controller_full;
  logic [HBM_DWIDTH-1:0] hbm_controller_edge;
  logic                  hbm_controller_valid;
  logic [AXI_AWIDTH-1:0] m_axi_araddr;
  logic [7:0]            m_axi_arlen;
  logic [2:0]            m_axi_arsize;
  logic [1:0]            m_axi_arburst;
  logic                  m_axi_arvalid;
  logic                  m_axi_arready;
  logic [HBM_DWIDTH-1:0] m_axi_rdata;
  logic [1:0]            m_axi_rresp;
  logic                  m_axi_rvalid;
  logic                  m_axi_rready;
  logic                  m_axi_rlast;
  logic                  resp_err;
  logic                  req_overflow;

  modport master (
    input  rd_hbm_edge_addr, rd_hbm_edge_valid, m_axi_arready, m_axi_rdata, m_axi_rresp,
           m_axi_rvalid, m_axi_rlast,
    output hbm_controller_full, hbm_controller_edge, hbm_controller_valid, m_axi_araddr,
           m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid, m_axi_rready, resp_err,
           req_overflow
  );

  modport slave (
    output rd_hbm_edge_addr, rd_hbm_edge_valid, m_axi_arready, m_axi_rdata, m_axi_rresp,
           m_axi_rvalid, m_axi_rlast,
    input  hbm_controller_full, hbm_controller_edge, hbm_controller_valid, m_axi_araddr,
           m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid, m_axi_rready, resp_err,
           req_overflow
  );
endinterface

// File: rtl/hbm_rd_responder_single.sv
// Per-pseudo-channel HBM read responder: queues edge-line word addresses, issues them as
// single-beat AXI4 reads under an outstanding limit, and forwards read data with 1-cycle latency.
module hbm_rd_responder_single #(
  parameter int unsigned HBM_AWIDTH      = 32,
  parameter int unsigned HBM_DWIDTH      = 256,
  parameter int unsigned AXI_AWIDTH      = 33,
  parameter int unsigned PSEUDO_ID       = 0,
  parameter int unsigned PC_SIZE_WIDTH   = 28,
  parameter int unsigned REQ_DEPTH       = 16,
  parameter int unsigned FULL_MARGIN     = 4,
  parameter int unsigned MAX_OUTSTANDING = 32
) (
  input logic                        clk,
  input logic                        rst,
  hbm_rd_responder_single_if.master  bus_io
);

  localparam int unsigned OffB = $clog2(HBM_DWIDTH / 8);
  localparam int unsigned PtrW = $clog2(REQ_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned OutW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [AXI_AWIDTH-1:0] Base = AXI_AWIDTH'(PSEUDO_ID) << PC_SIZE_WIDTH;

  typedef enum logic [0:0] {StIdle, StIssue} state_e;

  state_e                state_q;
  logic [AXI_AWIDTH-1:0] mem_q [REQ_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q, count_d, waiting;
  logic [OutW-1:0]       out_q, out_d;
  logic [AXI_AWIDTH-1:0] araddr_q, xlat_addr, head_addr;
  logic                  arvalid_q, full_q, valid_q, resp_err_q, overflow_q;
  logic [HBM_DWIDTH-1:0] edge_q;

  logic [HBM_AWIDTH-1:0]    req_addr;
  logic [PC_SIZE_WIDTH-1:0] win_off;
  logic                     push, ar_hs, r_dec, load;
  logic                     unused_rlast;

  assign req_addr     = bus_io.rd_hbm_edge_addr;
  assign unused_rlast = bus_io.m_axi_rlast;

  // Truncating to the window width before the shift drops the word bits beyond the window.
  assign win_off   = PC_SIZE_WIDTH'(req_addr) << OffB;
  assign xlat_addr = Base + AXI_AWIDTH'(win_off);

  // The entry shown on AR stays counted in count_q until accepted, so it occupies a slot.
  assign push    = bus_io.rd_hbm_edge_valid && (count_q != CntW'(REQ_DEPTH));
  assign ar_hs   = arvalid_q && bus_io.m_axi_arready;
  assign r_dec   = bus_io.m_axi_rvalid && (out_q != '0);
  assign out_d   = out_q + OutW'(ar_hs) - OutW'(r_dec);
  assign count_d = count_q + CntW'(push) - CntW'(ar_hs);
  assign waiting = count_q - CntW'(arvalid_q);

  // An empty queue forwards the incoming request straight to AR for single-cycle latency.
  assign head_addr = (waiting != '0) ? mem_q[rd_ptr_q] : xlat_addr;
  // Checking the post-update count keeps accepted-plus-presented reads within the limit.
  assign load = ((waiting != '0) || push) && (out_d < OutW'(MAX_OUTSTANDING)) &&
                (!arvalid_q || ar_hs);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= xlat_addr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      out_q      <= '0;
      araddr_q   <= '0;
      arvalid_q  <= 1'b0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      edge_q     <= '0;
      valid_q    <= 1'b0;
      resp_err_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (load) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q    <= count_d;
      out_q      <= out_d;
      full_q     <= (count_d >= CntW'(REQ_DEPTH - FULL_MARGIN));
      overflow_q <= overflow_q | (bus_io.rd_hbm_edge_valid & ~push);

      case (state_q)
        StIdle: begin
          if (load) begin
            araddr_q  <= head_addr;
            arvalid_q <= 1'b1;
            state_q   <= StIssue;
          end
        end
        StIssue: begin
          if (ar_hs) begin
            if (load) begin
              araddr_q <= head_addr;
            end else begin
              arvalid_q <= 1'b0;
              state_q   <= StIdle;
            end
          end
        end
        default: begin
          arvalid_q <= 1'b0;
          state_q   <= StIdle;
        end
      endcase

      valid_q <= bus_io.m_axi_rvalid;
      if (bus_io.m_axi_rvalid) edge_q <= bus_io.m_axi_rdata;
      resp_err_q <= resp_err_q | (bus_io.m_axi_rvalid & (bus_io.m_axi_rresp != 2'b00));
    end
  end

  assign bus_io.hbm_controller_full  = full_q;
  assign bus_io.hbm_controller_edge  = edge_q;
  assign bus_io.hbm_controller_valid = valid_q;
  assign bus_io.m_axi_araddr         = araddr_q;
  assign bus_io.m_axi_arlen          = 8'd0;
  assign bus_io.m_axi_arsize         = 3'(OffB);
  assign bus_io.m_axi_arburst        = 2'b01;
  assign bus_io.m_axi_arvalid        = arvalid_q;
  assign bus_io.m_axi_rready         = rst;
  assign bus_io.resp_err             = resp_err_q;
  assign bus_io.req_overflow         = overflow_q;

endmodule

// File: tb/tb_hbm_rd_responder_single.sv
// Bench for hbm_rd_responder_single: translation table, full/overflow, outstanding limit,
// error path and a randomized run against a queue-based AXI slave and reference model.
module tb_hbm_rd_responder_single;
  localparam int AW = 32, DW = 256, XW = 33, PID = 3, PCW = 28;
  localparam int DEPTH = 16, MARGIN = 4, MAXO = 32, NRAND = 200;
  localparam longint unsigned BYTES = 64'(DW / 8);
  localparam longint unsigned WIN   = 64'd1 << PCW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hbm_rd_responder_single_if #(.HBM_AWIDTH(AW), .HBM_DWIDTH(DW), .AXI_AWIDTH(XW)) bus ();

  hbm_rd_responder_single #(
    .HBM_AWIDTH(AW), .HBM_DWIDTH(DW), .AXI_AWIDTH(XW), .PSEUDO_ID(PID),
    .PC_SIZE_WIDTH(PCW), .REQ_DEPTH(DEPTH), .FULL_MARGIN(MARGIN), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_io(bus)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [XW-1:0] araddr;
  } vec_t;

  int checks = 0, errors = 0, hs_cnt = 0, r_cnt = 0;
  logic [XW-1:0] exp_ar[$];
  logic [XW-1:0] rq[$];
  logic [DW-1:0] exp_resp[$];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Byte address = channel base + word offset within the window, wrapped to the AXI width.
  function automatic logic [XW-1:0] xlat(input logic [AW-1:0] a);
    longint unsigned v;
    v = 64'(PID) * WIN + (64'(a) % (WIN / BYTES)) * BYTES;
    v = v % (64'd1 << XW);
    return v[XW-1:0];
  endfunction

  function automatic logic [DW-1:0] mkdata(input logic [XW-1:0] a);
    return {4{a[31:0], ~a[31:0]}};
  endfunction

  task automatic quiet();
    bus.rd_hbm_edge_valid = 1'b0;
    bus.rd_hbm_edge_addr  = '0;
    bus.m_axi_arready     = 1'b0;
    bus.m_axi_rvalid      = 1'b0;
    bus.m_axi_rdata       = '0;
    bus.m_axi_rresp       = 2'b00;
    bus.m_axi_rlast       = 1'b0;
  endtask

  task automatic reset_dut();
    @(posedge clk); #1;
    rst = 1'b0;
    quiet();
    exp_ar.delete(); rq.delete(); exp_resp.delete();
    hs_cnt = 0; r_cnt = 0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic send(input logic [AW-1:0] a, input bit expect_accept);
    bus.rd_hbm_edge_valid = 1'b1;
    bus.rd_hbm_edge_addr  = a;
    if (expect_accept) exp_ar.push_back(xlat(a));
  endtask

  // Slave model: returns accepted reads in order, one beat at a time.
  task automatic drive_r(input bit en);
    logic [XW-1:0] a;
    logic [DW-1:0] d;
    if (en && rq.size() > 0) begin
      a = rq.pop_front();
      d = mkdata(a);
      bus.m_axi_rvalid = 1'b1;
      bus.m_axi_rdata  = d;
      bus.m_axi_rresp  = 2'b00;
      bus.m_axi_rlast  = 1'b1;
      exp_resp.push_back(d);
      r_cnt++;
    end else begin
      bus.m_axi_rvalid = 1'b0;
      bus.m_axi_rlast  = 1'b0;
    end
  endtask

  // Observe half a cycle before the edge that completes each handshake / after each output update.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.m_axi_arvalid && bus.m_axi_arready) begin
        hs_cnt++;
        if (exp_ar.size() == 0) check("ar_unexpected", DW'(bus.m_axi_araddr), '0);
        else check("ar_addr_order", DW'(bus.m_axi_araddr), DW'(exp_ar.pop_front()));
        rq.push_back(bus.m_axi_araddr);
        check("inflight_max", DW'((hs_cnt - r_cnt) <= MAXO), DW'(1));
      end
      if (bus.hbm_controller_valid) begin
        if (exp_resp.size() == 0) check("resp_unexpected", bus.hbm_controller_edge, '1);
        else check("resp_data", bus.hbm_controller_edge, exp_resp.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[6];
    int sent, cyc, hs0;
    tbl[0] = '{32'h0000_0010, 33'h0_3000_0200};
    tbl[1] = '{32'h0000_0000, 33'h0_3000_0000};
    tbl[2] = '{32'h007F_FFFF, 33'h0_3FFF_FFE0};
    tbl[3] = '{32'h0080_0000, 33'h0_3000_0000};
    tbl[4] = '{32'hFFFF_FFFF, 33'h0_3FFF_FFE0};
    tbl[5] = '{32'h0012_3456, 33'h0_3246_8AC0};

    // Reset with busy inputs
    quiet();
    bus.rd_hbm_edge_valid = 1'b1;
    bus.rd_hbm_edge_addr  = 32'h1234_5678;
    bus.m_axi_arready = 1'b1;
    bus.m_axi_rvalid  = 1'b1;
    bus.m_axi_rdata   = '1;
    bus.m_axi_rresp   = 2'b10;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_full", DW'(bus.hbm_controller_full), '0);
    check("rst_edge", bus.hbm_controller_edge, '0);
    check("rst_valid", DW'(bus.hbm_controller_valid), '0);
    check("rst_arvalid", DW'(bus.m_axi_arvalid), '0);
    check("rst_araddr", DW'(bus.m_axi_araddr), '0);
    check("rst_resp_err", DW'(bus.resp_err), '0);
    check("rst_overflow", DW'(bus.req_overflow), '0);
    check("rst_rready", DW'(bus.m_axi_rready), '0);
    @(posedge clk); #1;
    quiet();
    rst = 1'b1;
    @(negedge clk);
    check("rel_full", DW'(bus.hbm_controller_full), '0);
    check("rel_rready", DW'(bus.m_axi_rready), DW'(1));

    // Translation table, one request at a time
    bus.m_axi_arready = 1'b1;
    foreach (tbl[i]) begin
      @(posedge clk); #1;
      bus.rd_hbm_edge_valid = 1'b1;
      bus.rd_hbm_edge_addr  = tbl[i].addr;
      exp_ar.push_back(tbl[i].araddr);
      @(posedge clk); #1;
      bus.rd_hbm_edge_valid = 1'b0;
      @(negedge clk);
      check("tbl_arvalid", DW'(bus.m_axi_arvalid), DW'(1));
      check("tbl_araddr", DW'(bus.m_axi_araddr), DW'(tbl[i].araddr));
      check("tbl_arlen", DW'(bus.m_axi_arlen), '0);
      check("tbl_arsize", DW'(bus.m_axi_arsize), DW'(5));
      check("tbl_arburst", DW'(bus.m_axi_arburst), DW'(1));
    end
    repeat (8) begin
      @(posedge clk); #1;
      drive_r(1'b1);
    end
    @(posedge clk); #1;
    drive_r(1'b0);
    repeat (2) @(negedge clk);
    check("tbl_resp_drained", DW'(exp_resp.size()), '0);

    // Queue full and overflow with AR stalled
    reset_dut();
    @(posedge clk); #1;
    send(AW'(7), 1'b1);
    for (int k = 1; k <= 17; k++) begin
      @(posedge clk); #1;
      if (k < 17) send(AW'((k + 1) * 7), (k + 1) <= DEPTH);
      else bus.rd_hbm_edge_valid = 1'b0;
      @(negedge clk);
      check("ovf_full", DW'(bus.hbm_controller_full), DW'(k >= 12));
      check("ovf_flag", DW'(bus.req_overflow), DW'(k >= 17));
    end
    hs0 = hs_cnt;
    @(posedge clk); #1;
    bus.m_axi_arready = 1'b1;
    repeat (24) @(negedge clk);
    check("ovf_ar_count", DW'(hs_cnt - hs0), DW'(DEPTH));
    check("ovf_ar_left", DW'(exp_ar.size()), '0);
    check("ovf_sticky", DW'(bus.req_overflow), DW'(1));
    check("ovf_full_clear", DW'(bus.hbm_controller_full), '0);

    // Outstanding limit, then simultaneous AR handshake and R beat
    reset_dut();
    bus.m_axi_arready = 1'b1;
    sent = 0;
    cyc  = 0;
    while (sent < 40 && cyc < 300) begin
      @(posedge clk); #1;
      if (!bus.hbm_controller_full) begin
        send($urandom(), 1'b1);
        sent++;
      end else begin
        bus.rd_hbm_edge_valid = 1'b0;
      end
      cyc++;
    end
    @(posedge clk); #1;
    bus.rd_hbm_edge_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("lim_sent", DW'(sent), DW'(40));
    check("lim_ar_count", DW'(hs_cnt), DW'(MAXO));
    check("lim_stalled", DW'(bus.m_axi_arvalid), '0);
    @(posedge clk); #1;
    drive_r(1'b1);
    for (int s = 0; s < 6; s++) begin
      @(posedge clk); #1;
      drive_r(1'b1);
      @(negedge clk);
      check("lim_issue_continues", DW'(bus.m_axi_arvalid), DW'(1));
    end
    @(posedge clk); #1;
    drive_r(1'b0);
    @(negedge clk);
    check("lim_last_before_limit", DW'(bus.m_axi_arvalid), DW'(1));
    @(posedge clk); #1;
    @(negedge clk);
    check("lim_restall", DW'(bus.m_axi_arvalid), '0);
    check("lim_ar_count2", DW'(hs_cnt), DW'(39));
    cyc = 0;
    while ((hs_cnt < 40 || rq.size() > 0 || exp_resp.size() > 0) && cyc < 300) begin
      @(posedge clk); #1;
      drive_r(1'b1);
      cyc++;
    end
    check("lim_drain_timeout", DW'(cyc < 300), DW'(1));
    check("lim_ar_total", DW'(hs_cnt), DW'(40));

    // Error response at zero outstanding still forwarded
    reset_dut();
    @(posedge clk); #1;
    bus.m_axi_rvalid = 1'b1;
    bus.m_axi_rdata  = {32{8'hA5}};
    bus.m_axi_rresp  = 2'b10;
    exp_resp.push_back({32{8'hA5}});
    @(posedge clk); #1;
    bus.m_axi_rvalid = 1'b0;
    bus.m_axi_rdata  = '0;
    bus.m_axi_rresp  = 2'b00;
    @(negedge clk);
    check("err_valid", DW'(bus.hbm_controller_valid), DW'(1));
    check("err_edge", bus.hbm_controller_edge, {32{8'hA5}});
    check("err_flag", DW'(bus.resp_err), DW'(1));
    @(negedge clk);
    check("err_valid_drop", DW'(bus.hbm_controller_valid), '0);
    check("err_edge_hold", bus.hbm_controller_edge, {32{8'hA5}});
    check("err_sticky", DW'(bus.resp_err), DW'(1));

    // Randomized traffic against the slave model
    reset_dut();
    sent = 0;
    cyc  = 0;
    while ((sent < NRAND || hs_cnt < NRAND || rq.size() > 0 || exp_resp.size() > 0)
           && cyc < 4000) begin
      @(posedge clk); #1;
      if (sent < NRAND && !bus.hbm_controller_full && $urandom_range(0, 3) != 0) begin
        send($urandom(), 1'b1);
        sent++;
      end else begin
        bus.rd_hbm_edge_valid = 1'b0;
      end
      bus.m_axi_arready = ($urandom_range(0, 2) != 0);
      drive_r($urandom_range(0, 2) != 0);
      cyc++;
    end
    check("rnd_timeout", DW'(cyc < 4000), DW'(1));
    check("rnd_ar_total", DW'(hs_cnt), DW'(NRAND));
    check("rnd_r_total", DW'(r_cnt), DW'(NRAND));
    check("rnd_resp_err", DW'(bus.resp_err), '0);
    check("rnd_overflow", DW'(bus.req_overflow), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
